// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one forward round per clock on a 128-bit state register,
// driven by a pre-expanded key schedule, with valid/ready handshakes on both sides.
module aes_cipher_iter #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          input_bytes,
    input  logic [128*(NR+1)-1:0] ExpandedKeys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    localparam logic [3:0] ROUND_LAST = 4'(NR);

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte n sits at [127-8n -: 8]; byte n is row n%4, column n/4.
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic [127:0] out_q;
    logic [3:0]   round_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [127:0] roundKey;
    logic [127:0] shifted;
    logic [127:0] state_d;
    logic [127:0] out_d;

    always_comb begin
        roundKey = ExpandedKeys[128*int'(round_q) +: 128];
        shifted  = shiftRows(subBytes(state_q));
        state_d  = mixColumns(shifted) ^ roundKey;
        out_d    = shifted ^ roundKey;
    end

    // Handshake flags are registered alongside the FSM so they change only on edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            out_q       <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= input_bytes ^ ExpandedKeys[127:0];
                        round_q    <= 4'd1;
                        in_ready_q <= 1'b0;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    if (round_q == ROUND_LAST) begin
                        out_q       <= out_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        state_q <= state_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: known-answer vectors, random blocks against a
// GF(2^8)-derived AES model, backpressure, back-to-back throughput and mid-block reset.
module tb_aes_cipher_iter;

    localparam int NR = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [127:0]          input_bytes;
    logic [128*(NR+1)-1:0] ExpandedKeys;
    logic                  out_valid;
    logic                  out_ready;
    logic [127:0]          out;

    int errors = 0;
    int checks = 0;
    int stepCount = 0;

    logic [7:0]   sboxT [256];
    logic [7:0]   invSboxT [256];
    logic [127:0] rkeys [NR+1];

    aes_cipher_iter #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .input_bytes(input_bytes),
        .ExpandedKeys(ExpandedKeys),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    // Reference model: S-box derived from GF(2^8) inverse plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic buildTables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sboxT[a[7:0]] = s;
            invSboxT[s]   = a[7:0];
        end
    endtask

    function automatic logic [7:0] getB(input logic [127:0] blk, input int row, input int col);
        return blk[127 - 8*(row + 4*col) -: 8];
    endfunction

    task automatic setKey(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4*(NR+1); i++) begin
            if (i < 4) begin
                w[i] = key[127 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]};
                    t = t ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end
                w[i] = w[i-4] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++) begin
            rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            ExpandedKeys[128*r +: 128] = rkeys[r];
        end
    endtask

    function automatic logic [127:0] modelEncrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        s = pt ^ rkeys[0];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(r + 4*c) -: 8] = sboxT[getB(s, r, (c + r) % 4)];
            s = t;
            if (rnd < NR) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[127 - 8*(r + 4*c) -: 8] = gmul(8'h02, getB(s, r, c)) ^ gmul(8'h03, getB(s, (r+1)%4, c))
                                                  ^ getB(s, (r+2)%4, c) ^ getB(s, (r+3)%4, c);
                s = t;
            end
            s = s ^ rkeys[rnd];
        end
        return s;
    endfunction

    function automatic logic [127:0] modelDecrypt(input logic [127:0] ct);
        logic [127:0] s;
        logic [127:0] t;
        s = ct ^ rkeys[NR];
        for (int rnd = NR - 1; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(r + 4*c) -: 8] = invSboxT[getB(s, r, (c - r + 4) % 4)];
            s = t ^ rkeys[rnd];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[127 - 8*(r + 4*c) -: 8] = gmul(8'h0e, getB(s, r, c)) ^ gmul(8'h0b, getB(s, (r+1)%4, c))
                                                  ^ gmul(8'h0d, getB(s, (r+2)%4, c)) ^ gmul(8'h09, getB(s, (r+3)%4, c));
                s = t;
            end
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        stepCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
    endtask

    task automatic waitValid();
        int n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
    endtask

    // Runs one block end to end: accept, latency, ciphertext, consume.
    task automatic applyStimulus(input logic [127:0] pt, input string tag, output logic [127:0] ct);
        int accept;
        in_valid    = 1'b1;
        input_bytes = pt;
        waitReady();
        checkBit({tag, " ready"}, in_ready, 1'b1);
        step();
        accept      = stepCount;
        in_valid    = 1'b0;
        input_bytes = {$urandom, $urandom, $urandom, $urandom};
        checkBit({tag, " busy"}, in_ready, 1'b0);
        waitValid();
        checkOutput({tag, " latency"}, 128'(stepCount - accept), 128'(NR));
        checkOutput({tag, " out"}, out, modelEncrypt(pt));
        ct = out;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkBit({tag, " consumed"}, out_valid, 1'b0);
        checkBit({tag, " idle"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] exp;
        logic [127:0] ptB;
        int           acceptA;
        int           acceptB;
        int           n;
        logic         seen;
        logic         gotA;

        buildTables();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input_bytes = '0;
        setKey(128'h000102030405060708090a0b0c0d0e0f);
        step(); step();
        checkBit("reset in_ready", in_ready, 1'b1);
        checkBit("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out", out, 128'h0);
        rst = 1'b0;
        step();

        $display("[TB] FIPS-197 C.1 vector");
        pt = 128'h00112233445566778899aabbccddeeff;
        applyStimulus(pt, "C.1", ct);
        checkOutput("C.1 known", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("C.1 roundtrip", modelDecrypt(ct), pt);

        $display("[TB] all-zero key and plaintext");
        setKey(128'h0);
        applyStimulus(128'h0, "zero", ct);
        checkOutput("zero known", ct, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        $display("[TB] backpressure");
        setKey({$urandom, $urandom, $urandom, $urandom});
        pt = {$urandom, $urandom, $urandom, $urandom};
        exp = modelEncrypt(pt);
        in_valid = 1'b1; input_bytes = pt;
        waitReady();
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        waitValid();
        checkOutput("bp first", out, exp);
        for (int i = 0; i < 20; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            input_bytes = {$urandom, $urandom, $urandom, $urandom};
            step();
            checkBit("bp out_valid", out_valid, 1'b1);
            checkOutput("bp out", out, exp);
            checkBit("bp in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkBit("bp released", in_ready, 1'b1);

        $display("[TB] back-to-back");
        pt  = {$urandom, $urandom, $urandom, $urandom};
        ptB = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1; out_ready = 1'b1; input_bytes = pt;
        waitReady();
        step();
        acceptA = stepCount;
        acceptB = 0;
        input_bytes = ptB;
        gotA = 1'b0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (out_valid && !gotA) begin
                checkOutput("b2b first", out, modelEncrypt(pt));
                gotA = 1'b1;
            end
            if (in_ready) begin
                step();
                acceptB = stepCount;
                break;
            end
        end
        in_valid = 1'b0;
        checkBit("b2b first seen", gotA, 1'b1);
        checkOutput("b2b spacing", 128'(acceptB - acceptA), 128'(NR + 2));
        waitValid();
        checkOutput("b2b second", out, modelEncrypt(ptB));
        step();
        out_ready = 1'b0;
        checkBit("b2b idle", in_ready, 1'b1);

        $display("[TB] reset mid-block");
        setKey(128'h000102030405060708090a0b0c0d0e0f);
        in_valid = 1'b1; input_bytes = 128'h00112233445566778899aabbccddeeff;
        waitReady();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkBit("abort in_ready", in_ready, 1'b1);
        checkBit("abort out_valid", out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checkBit("abort no pulse", seen, 1'b0);
        checkBit("abort still idle", in_ready, 1'b1);
        applyStimulus(128'h00112233445566778899aabbccddeeff, "C.1 again", ct);
        checkOutput("C.1 again known", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        $display("[TB] random blocks");
        for (int i = 0; i < 4; i++) begin
            setKey({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(pt, "random", ct);
            checkOutput("random roundtrip", modelDecrypt(ct), pt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
